// File: rtl/restador_serial.sv
// Bit-serial N-bit subtractor D = A - B - Bin, one bit per clock, LSB first,
// with a start/busy/done handshake toward the controlling FSM.
module restador_serial #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic [N-1:0] D,
    output logic         Bout,
    output logic         V,
    output logic         busy,
    output logic         done
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic [N-1:0]  res_reg;
    logic [CW-1:0] cnt;
    logic          borrow;
    logic          a_msb;
    logic          b_msb;

    logic bit_a;
    logic bit_b;
    logic d_bit;
    logic borrow_next;
    logic last_bit;

    // Full-subtractor cell: the adder's ripple cell with borrow in place of carry.
    assign bit_a       = a_reg[0];
    assign bit_b       = b_reg[0];
    assign d_bit       = bit_a ^ bit_b ^ borrow;
    assign borrow_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow);
    assign last_bit    = (cnt == CW'(N - 1));

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets its default before the case; without it any path
    // that skips an assignment would infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every datapath register is reset explicitly so an aborted
    // operation leaves no stale bits behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            cnt     <= '0;
            borrow  <= 1'b0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            D       <= '0;
            Bout    <= 1'b0;
            V       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            // Handshake flags are flopped from the next state so they stay registered.
            busy <= (state_next == SHIFT);
            done <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg  <= A;
                        b_reg  <= B;
                        borrow <= Bin;
                        cnt    <= '0;
                        a_msb  <= A[N-1];
                        b_msb  <= B[N-1];
                    end
                end
                SHIFT: begin
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    res_reg <= {d_bit, res_reg[N-1:1]};
                    borrow  <= borrow_next;
                    cnt     <= cnt + CW'(1);
                    if (last_bit) begin
                        D    <= {d_bit, res_reg[N-1:1]};
                        Bout <= borrow_next;
                        // Signed overflow: operand signs differ and the result sign left A's.
                        V    <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_restador_serial.sv
// Self-checking bench for restador_serial: an arithmetic model of A - B - Bin
// plus an elapsed-cycle timing model, compared against N=8 and N=4 instances.
module tb_restador_serial;

    logic clk = 1'b0;
    logic rst;

    logic       start8, Bin8;
    logic [7:0] A8, B8;
    logic [7:0] D8;
    logic       Bout8, V8, busy8, done8;

    logic       start4, Bin4;
    logic [3:0] A4, B4;
    logic [3:0] D4;
    logic       Bout4, V4, busy4, done4;

    int n_checks = 0;
    int n_errors = 0;
    int done4_cnt = 0;
    bit armed = 1'b0;

    int e8 = 0, pa8, pb8, pbin8, xd8 = 0, xbo8 = 0, xv8 = 0;
    int e4 = 0, pa4, pb4, pbin4, xd4 = 0, xbo4 = 0, xv4 = 0;

    always #5 clk = ~clk;

    restador_serial #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(A8), .B(B8), .Bin(Bin8),
        .D(D8), .Bout(Bout8), .V(V8), .busy(busy8), .done(done8)
    );

    restador_serial #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .A(A4), .B(B4), .Bin(Bin4),
        .D(D4), .Bout(Bout4), .V(V4), .busy(busy4), .done(done4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result of A - B - Bin in n bits, from integer arithmetic.
    function automatic void model(input int n, input int a, input int b, input int bin,
                                  output int d, output int bout, output int v);
        int diff, sa, sb, sd;
        diff = a - b - bin;
        d    = diff & ((1 << n) - 1);
        bout = (diff < 0) ? 1 : 0;
        sa   = (a >= (1 << (n - 1))) ? a - (1 << n) : a;
        sb   = (b >= (1 << (n - 1))) ? b - (1 << n) : b;
        sd   = sa - sb - bin;
        v    = (sd < -(1 << (n - 1)) || sd > (1 << (n - 1)) - 1) ? 1 : 0;
    endfunction

    // e = cycles elapsed since the accepting edge; 0 means idle.
    always @(posedge clk) begin
        if (rst) begin
            armed = 1'b1;
            e8 = 0; xd8 = 0; xbo8 = 0; xv8 = 0;
        end else if (e8 == 0) begin
            if (start8) begin
                pa8 = int'(A8); pb8 = int'(B8); pbin8 = int'(Bin8); e8 = 1;
            end
        end else if (e8 == 9) begin
            e8 = 0;
        end else begin
            e8++;
            if (e8 == 9) model(8, pa8, pb8, pbin8, xd8, xbo8, xv8);
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            e4 = 0; xd4 = 0; xbo4 = 0; xv4 = 0;
        end else if (e4 == 0) begin
            if (start4) begin
                pa4 = int'(A4); pb4 = int'(B4); pbin4 = int'(Bin4); e4 = 1;
            end
        end else if (e4 == 5) begin
            e4 = 0;
        end else begin
            e4++;
            if (e4 == 5) model(4, pa4, pb4, pbin4, xd4, xbo4, xv4);
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("busy8", busy8, (e8 >= 1 && e8 <= 8));
            check("done8", done8, (e8 == 9));
            check("D8",    D8,    xd8);
            check("Bout8", Bout8, xbo8);
            check("V8",    V8,    xv8);
            check("busy4", busy4, (e4 >= 1 && e4 <= 4));
            check("done4", done4, (e4 == 5));
            check("D4",    D4,    xd4);
            check("Bout4", Bout4, xbo4);
            check("V4",    V4,    xv4);
            check("busy_done_excl8", busy8 & done8, 0);
            if (done4) done4_cnt++;
        end
    end

    // Start one N=8 operation; inputs are scrambled after acceptance and an
    // optional stray start (A=10, B=4) is raised during SHIFT.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin, input bit poke);
        int lat;
        @(negedge clk);
        A8 = a; B8 = b; Bin8 = bin; start8 = 1'b1;
        lat = -1;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            start8 = 1'b0;
            A8 = 8'($urandom); B8 = 8'($urandom); Bin8 = 1'($urandom);
            if (poke && j == 3) begin
                start8 = 1'b1; A8 = 8'd10; B8 = 8'd4;
            end
            if (done8) begin
                lat = j;
                break;
            end
        end
        start8 = 1'b0;
        check("latency8", lat, 9);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin);
        int lat, d, bo, v;
        @(negedge clk);
        A4 = a; B4 = b; Bin4 = bin; start4 = 1'b1;
        lat = -1;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            start4 = 1'b0;
            A4 = 4'($urandom); B4 = 4'($urandom);
            if (done4) begin
                lat = j;
                break;
            end
        end
        check("latency4", lat, 5);
        model(4, int'(a), int'(b), int'(bin), d, bo, v);
        check("sweep_D4", D4, d);
        check("sweep_Bout4", Bout4, bo);
        check("sweep_V4", V4, v);
    endtask

    initial begin
        bit saw_done;
        rst = 1'b1;
        start8 = 1'b0; A8 = '0; B8 = '0; Bin8 = 1'b0;
        start4 = 1'b0; A4 = '0; B4 = '0; Bin4 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_D8", D8, 0);
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        rst = 1'b0;

        op8(8'd5, 8'd3, 1'b0, 1'b0);
        check("5-3 D", D8, 8'd2);   check("5-3 Bout", Bout8, 0); check("5-3 V", V8, 0);
        op8(8'd3, 8'd5, 1'b0, 1'b0);
        check("3-5 D", D8, 8'hFE);  check("3-5 Bout", Bout8, 1); check("3-5 V", V8, 0);
        op8(8'd0, 8'd0, 1'b1, 1'b0);
        check("0-0-1 D", D8, 8'hFF); check("0-0-1 Bout", Bout8, 1); check("0-0-1 V", V8, 0);
        op8(8'hFF, 8'hFF, 1'b0, 1'b1);
        check("FF-FF D", D8, 8'h00); check("FF-FF Bout", Bout8, 0); check("FF-FF V", V8, 0);
        @(negedge clk);
        check("poke_ignored_idle", busy8, 0);
        op8(8'h80, 8'h01, 1'b0, 1'b0);
        check("80-1 D", D8, 8'h7F); check("80-1 Bout", Bout8, 0); check("80-1 V", V8, 1);

        // Abort on the 4th SHIFT cycle.
        @(negedge clk);
        A8 = 8'd9; B8 = 8'd2; Bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_D", D8, 0); check("abort_Bout", Bout8, 0); check("abort_V", V8, 0);
        check("abort_busy", busy8, 0); check("abort_done", done8, 0);
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        op8(8'd9, 8'd2, 1'b0, 1'b0);
        check("9-2 D", D8, 8'd7); check("9-2 Bout", Bout8, 0);

        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int bin = 0; bin < 2; bin++)
                    op4(4'(a), 4'(b), 1'(bin));
        @(negedge clk);
        check("done4_count", done4_cnt, 512);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
